// File: rtl/cam_tx.sv
// cam_tx: AXI4-Stream video slave to parallel FV/LV/D_OUT sensor interface with programmable porches.
// Define CAM_TX_TPG_EN to add the tpg_en input and the {line, pixel} test-pattern frame source.
module cam_tx #(
    parameter int WIDTH     = 480,
    parameter int HEIGHT    = 640,
    parameter int H_B_PORCH = 120,
    parameter int H_F_PORCH = 200,
    parameter int V_B_PORCH = 120,
    parameter int V_F_PORCH = 100,
    parameter int FRAME_GAP = 64
) (
    input  logic        pclk,
    input  logic        reset,
`ifdef CAM_TX_TPG_EN
    input  logic        tpg_en,
`endif
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    output logic        FV,
    output logic        LV,
    output logic [15:0] D_OUT,
    output logic        frame_done,
    output logic        err_underrun,
    output logic        err_tlast,
    output logic        err_sof
);
    localparam int M1   = WIDTH > H_B_PORCH ? WIDTH : H_B_PORCH;
    localparam int M2   = M1 > H_F_PORCH ? M1 : H_F_PORCH;
    localparam int M3   = M2 > V_B_PORCH ? M2 : V_B_PORCH;
    localparam int M4   = M3 > V_F_PORCH ? M3 : V_F_PORCH;
    localparam int MAXP = M4 > FRAME_GAP ? M4 : FRAME_GAP;
    localparam int CW   = $clog2(MAXP + 1);
    localparam int LW   = $clog2(HEIGHT + 1);

    typedef enum logic [2:0] {WAIT_SOF, VBP, HBP, ACTIVE, HFP, VFP, GAP} state_t;

    // Zero-length porches are skipped by resolving entry points at elaboration time
    localparam state_t S_LINE  = (H_B_PORCH > 0) ? HBP : ACTIVE;
    localparam state_t S_END   = (V_F_PORCH > 0) ? VFP : GAP;
    localparam state_t S_FRAME = (V_B_PORCH > 0) ? VBP : S_LINE;

    state_t          state, state_n, nxt_line;
    logic [CW-1:0]   cnt, lim;
    logic [LW-1:0]   line;
    logic            last, eol, in_frame, active, accept, tpg, start;

`ifdef CAM_TX_TPG_EN
    always_ff @(posedge pclk or posedge reset)
        if (reset) tpg <= 1'b0;
        else if (state == WAIT_SOF) tpg <= tpg_en;
    assign start = tpg_en | (s_axis_tvalid & s_axis_tuser);
    assign s_axis_tready = ~reset & (state == WAIT_SOF ? s_axis_tvalid & ~s_axis_tuser & ~tpg_en
                                                       : active & ~tpg);
`else
    assign tpg   = 1'b0;
    assign start = s_axis_tvalid & s_axis_tuser;
    assign s_axis_tready = ~reset & (state == WAIT_SOF ? s_axis_tvalid & ~s_axis_tuser : active);
`endif

    assign in_frame = state inside {VBP, HBP, ACTIVE, HFP, VFP};
    assign active   = state == ACTIVE;
    assign accept   = s_axis_tvalid & s_axis_tready;

    always_comb begin
        lim = state == VBP    ? CW'(V_B_PORCH - 1) :
              state == HBP    ? CW'(H_B_PORCH - 1) :
              state == ACTIVE ? CW'(WIDTH - 1)     :
              state == HFP    ? CW'(H_F_PORCH - 1) :
              state == VFP    ? CW'(V_F_PORCH - 1) : CW'(FRAME_GAP - 1);
        last     = cnt == lim;
        eol      = last & (state == HFP | (active & H_F_PORCH == 0));
        nxt_line = line == LW'(HEIGHT - 1) ? S_END : S_LINE;
        state_n  = state == WAIT_SOF ? (start ? S_FRAME : WAIT_SOF) :
                   !last             ? state :
                   state == VBP      ? S_LINE :
                   state == HBP      ? ACTIVE :
                   state == ACTIVE   ? (H_F_PORCH > 0 ? HFP : nxt_line) :
                   state == HFP      ? nxt_line :
                   state == VFP      ? GAP : WAIT_SOF;
    end

    always_ff @(posedge pclk or posedge reset)
        if (reset) begin
            state        <= WAIT_SOF;
            cnt          <= '0;
            line         <= '0;
            FV           <= 1'b0;
            LV           <= 1'b0;
            D_OUT        <= '0;
            frame_done   <= 1'b0;
            err_underrun <= 1'b0;
            err_tlast    <= 1'b0;
            err_sof      <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= (state == WAIT_SOF || last) ? '0 : cnt + 1'b1;
            line         <= state == WAIT_SOF ? '0 : eol ? line + 1'b1 : line;
            FV           <= in_frame;
            LV           <= active;
            D_OUT        <= !active ? '0 : tpg ? {8'(line), 8'(cnt)} : accept ? s_axis_tdata : '0;
            frame_done   <= FV & ~in_frame;
            err_underrun <= active & ~tpg & ~s_axis_tvalid;
            err_tlast    <= active & ~tpg & accept & (s_axis_tlast != last);
            err_sof      <= active & ~tpg & accept & s_axis_tuser & (|line | |cnt);
        end
endmodule

// File: tb/tb_cam_tx.sv
// tb_cam_tx: table-driven frame scenarios for cam_tx plus hand-written reset and pattern-generator sequences.
module tb_cam_tx;
    localparam int W = 4, H = 2, HB = 3, HF = 2, VB = 3, VF = 2, FG = 4;

    logic        pclk = 1'b0, reset = 1'b1;
    logic [15:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0, s_axis_tuser = 1'b0, s_axis_tlast = 1'b0;
    logic        s_axis_tready, FV, LV, frame_done, err_underrun, err_tlast, err_sof;
    logic [15:0] D_OUT;
`ifdef CAM_TX_TPG_EN
    logic        tpg_en = 1'b0;
`endif

    cam_tx #(.WIDTH(W), .HEIGHT(H), .H_B_PORCH(HB), .H_F_PORCH(HF),
             .V_B_PORCH(VB), .V_F_PORCH(VF), .FRAME_GAP(FG)) dut (
        .pclk(pclk), .reset(reset),
`ifdef CAM_TX_TPG_EN
        .tpg_en(tpg_en),
`endif
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
        .FV(FV), .LV(LV), .D_OUT(D_OUT), .frame_done(frame_done),
        .err_underrun(err_underrun), .err_tlast(err_tlast), .err_sof(err_sof));

    always #5 pclk = ~pclk;

    typedef struct {logic [15:0] data; bit user; bit last; int gap; bit junk;} beat_t;
    typedef struct {string name; int junk, drop, early, miss, stray, e_fv, e_lv, e_und, e_tl, e_sof;} vec_t;

    beat_t bq[$];
    int    eq[$], dq[$];
    vec_t  vt[6];
    int    n_chk = 0, n_fail = 0;
    int    fv_cnt, lv_cnt, und_cnt, tl_cnt, sof_cnt, fd_cnt, rdy_cnt, junk_w;
    bit    mon = 0, abort = 0;
    time   t_sof, t_fv;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge pclk) if (mon) begin
        fv_cnt  += int'(FV);
        lv_cnt  += int'(LV);
        und_cnt += int'(err_underrun);
        tl_cnt  += int'(err_tlast);
        sof_cnt += int'(err_sof);
        fd_cnt  += int'(frame_done);
        rdy_cnt += int'(s_axis_tready);
        if (FV && t_fv == 0) t_fv = $time;
        if (LV) dq.push_back(int'(D_OUT));
    end

    task automatic clear_mon();
        fv_cnt = 0; lv_cnt = 0; und_cnt = 0; tl_cnt = 0; sof_cnt = 0; fd_cnt = 0; rdy_cnt = 0;
        junk_w = 0; t_sof = 0; t_fv = 0;
        dq.delete();
    endtask

    task automatic build(input int v);
        int g = 0;
        logic [15:0] d;
        bq.delete();
        eq.delete();
        for (int j = 0; j < vt[v].junk; j++) bq.push_back('{16'h5A00 + 16'(j), 1'b0, 1'b0, 0, 1'b1});
        for (int i = 0; i < W * H; i++) begin
            if (i == vt[v].drop) begin
                g = 1;
                eq.push_back(0);
                continue;
            end
            d = 16'hA000 + 16'(v * 16 + i);
            bq.push_back('{d, i == 0 || i == vt[v].stray, (i % W == W - 1 && i != vt[v].miss) || i == vt[v].early, g, 1'b0});
            eq.push_back(int'(d));
            g = 0;
        end
    endtask

    task automatic drive();
        int w;
        for (int i = 0; i < bq.size(); i++) begin
            if (abort) break;
            for (int g = 0; g < bq[i].gap; g++) begin
                @(negedge pclk);
                s_axis_tvalid = 1'b0;
            end
            @(negedge pclk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = bq[i].data;
            s_axis_tuser  = bq[i].user;
            s_axis_tlast  = bq[i].last;
            if (bq[i].user && t_sof == 0) t_sof = $time;
            #1;
            w = 0;
            while (!s_axis_tready && w < 100 && !abort) begin
                @(negedge pclk);
                #1;
                w++;
            end
            if (w == 100) chk("accept_timeout", w, 0);
            if (bq[i].junk) junk_w += w;
        end
        @(negedge pclk);
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_frame();
        int w = 0;
        while (fd_cnt == 0 && w < 200) begin
            @(negedge pclk);
            w++;
        end
        repeat (FG + 2) @(negedge pclk);
        mon = 0;
    endtask

    task automatic run_vec(input int v);
        build(v);
        clear_mon();
        mon = 1;
        drive();
        wait_frame();
        chk({vt[v].name, ".fv_len"}, fv_cnt, vt[v].e_fv);
        chk({vt[v].name, ".lv_len"}, lv_cnt, vt[v].e_lv);
        chk({vt[v].name, ".underrun"}, und_cnt, vt[v].e_und);
        chk({vt[v].name, ".tlast"}, tl_cnt, vt[v].e_tl);
        chk({vt[v].name, ".sof"}, sof_cnt, vt[v].e_sof);
        chk({vt[v].name, ".frame_done"}, fd_cnt, 1);
        chk({vt[v].name, ".fv_delay"}, int'((t_fv - t_sof) / 10), 2);
        chk({vt[v].name, ".junk_wait"}, junk_w, 0);
        chk({vt[v].name, ".n_pix"}, dq.size(), eq.size());
        for (int k = 0; k < eq.size(); k++)
            chk($sformatf("%s.d_out[%0d]", vt[v].name, k), k < dq.size() ? dq[k] : -1, eq[k]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, rdy, fvn;
        vt[0] = '{"nominal",  0, -1, -1, -1, -1, 23, 8, 0, 0, 0};
        vt[1] = '{"resync",   5, -1, -1, -1, -1, 23, 8, 0, 0, 0};
        vt[2] = '{"underrun", 0,  6, -1, -1, -1, 23, 8, 1, 0, 0};
        vt[3] = '{"early_tl", 0, -1,  1, -1, -1, 23, 8, 0, 1, 0};
        vt[4] = '{"miss_tl",  0, -1, -1,  3, -1, 23, 8, 0, 1, 0};
        vt[5] = '{"stray_sof",0, -1, -1, -1,  4, 23, 8, 0, 0, 1};

        #1;
        chk("rst.fv", FV, 0);
        chk("rst.lv", LV, 0);
        chk("rst.d_out", D_OUT, 0);
        chk("rst.tready", s_axis_tready, 0);
        chk("rst.pulses", {frame_done, err_underrun, err_tlast, err_sof}, 0);
        repeat (2) @(negedge pclk);
        reset = 1'b0;
        repeat (2) @(negedge pclk);

        for (int v = 0; v < 6; v++) run_vec(v);

        // Asynchronous reset in the middle of the active region
        build(0);
        t_sof = 0;
        abort = 0;
        fork drive(); join_none
        w = 0;
        while (!LV && w < 100) begin
            @(negedge pclk);
            w++;
        end
        chk("midrst.reached_lv", LV, 1);
        #2 reset = 1'b1;
        #1;
        chk("midrst.fv", FV, 0);
        chk("midrst.lv", LV, 0);
        chk("midrst.tready", s_axis_tready, 0);
        abort = 1;
        repeat (4) @(negedge pclk);
        abort = 0;
        reset = 1'b0;
        rdy = 0;
        fvn = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            s_axis_tvalid = 1'b1;
            s_axis_tuser  = 1'b0;
            s_axis_tdata  = 16'h1234;
            #1;
            rdy += int'(s_axis_tready);
            fvn += int'(FV);
        end
        @(negedge pclk);
        s_axis_tvalid = 1'b0;
        chk("postrst.drop_ready", rdy, 10);
        chk("postrst.fv_low", fvn, 0);
        run_vec(0);

`ifdef CAM_TX_TPG_EN
        clear_mon();
        mon = 1;
        @(negedge pclk);
        tpg_en = 1'b1;
        @(negedge pclk);
        tpg_en = 1'b0;
        wait_frame();
        chk("tpg.fv_len", fv_cnt, 23);
        chk("tpg.tready", rdy_cnt, 0);
        chk("tpg.underrun", und_cnt, 0);
        chk("tpg.n_pix", dq.size(), 8);
        chk("tpg.l1p3", dq.size() > 7 ? dq[7] : -1, 16'h0103);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cam_tx.md
Name: cam_tx

Overview:
- Camera-side transmitter: accepts a 16-bit AXI4-Stream video slave stream and drives the parallel sensor interface (FV, LV, D_OUT) with programmable porches.
- It is the counterpart of the capture block (FV/LV/D_IN to AXI-Stream master).
- Used as a sensor emulator in loop-back benches and as a video output stage on pclk.
- Single clock domain.

Parameters:
- WIDTH, 480, active pixels per line.
- HEIGHT, 640, active lines per frame.
- H_B_PORCH, 120, LV-low cycles before each line (FV high).
- H_F_PORCH, 200, LV-low cycles after each line (FV high).
- V_B_PORCH, 120, cycles from FV rise to the first line's H_B_PORCH.
- V_F_PORCH, 100, cycles of FV high after the last line's H_F_PORCH.
- FRAME_GAP, 64, FV-low cycles after each frame before looking for the next SOF (minimum 1).

Ports:
- pclk  in  1  pixel clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  16  pixel data.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accept.
- s_axis_tuser  in  1  start of frame (first pixel of a frame).
- s_axis_tlast  in  1  end of line (last pixel of a line).
- FV  out  1  frame valid.
- LV  out  1  line valid.
- D_OUT  out  16  pixel data; meaningful only while LV=1.
- frame_done  out  1  one-cycle pulse when FV falls.
- err_underrun  out  1  one-cycle pulse per active cycle with no valid beat.
- err_tlast  out  1  one-cycle pulse on tlast mismatch.
- err_sof  out  1  one-cycle pulse on tuser seen on a non-first pixel.

Behaviour:
- Reset (async, active-high): all outputs 0, s_axis_tready=0, FSM=WAIT_SOF, all counters 0. Reset mid-frame aborts immediately; FV/LV drop at once.
- FV, LV, D_OUT and error/done pulses are registered. They reflect the state and accepted beat of the previous cycle (1-cycle latency). s_axis_tready is combinational from the FSM state.
- States: WAIT_SOF, VBP, HBP, ACTIVE, HFP, VFP, GAP.
- WAIT_SOF:
  - FV=0.
  - tvalid=1 and tuser=0: tready=1, beat is dropped (resync).
  - tvalid=1 and tuser=1: tready=0, SOF beat is held; go to VBP.
  - tvalid=0: stay.
- VBP: FV=1 for V_B_PORCH cycles, then HBP with line count = 0.
- HBP: FV=1, LV=0 for H_B_PORCH cycles, then ACTIVE with pixel count = 0.
- ACTIVE: exactly WIDTH cycles; timing never stretches.
  - tready=1 every cycle.
  - Accepted beat: next cycle LV=1, D_OUT=tdata.
  - No valid beat: next cycle LV=1, D_OUT=16'h0000, err_underrun pulse.
  - Pixel WIDTH-1 accepted with tlast=0, or any earlier pixel accepted with tlast=1: err_tlast pulse. Data continues unchanged; no resync.
  - tuser=1 on any accepted beat other than line 0, pixel 0: err_sof pulse. The beat is still output.
  - After pixel WIDTH-1, go to HFP.
- HFP: LV=0 for H_F_PORCH cycles. Then HBP with line+1 if line < HEIGHT-1, else VFP.
- VFP: FV=1 for V_F_PORCH cycles, then GAP. frame_done pulses in the cycle FV goes 0.
- GAP: FV=0, tready=0 for FRAME_GAP cycles, then WAIT_SOF.
- A porch parameter of 0 skips that state (0 cycles).
- Counter widths: $clog2(max(param)+1). Counters wrap only by explicit clear, never by overflow.
- Frame period = V_B_PORCH + HEIGHT*(H_B_PORCH+WIDTH+H_F_PORCH) + V_F_PORCH + FRAME_GAP + WAIT_SOF cycles.
- Simultaneous underrun on the last pixel: err_underrun pulses, err_tlast does not (no beat to check).

Optional Feature:
- Macro CAM_TX_TPG_EN adds an input port tpg_en (1 bit), sampled in WAIT_SOF.
- If tpg_en=1: go directly to VBP without consuming a beat, and hold tready=0 for the whole frame.
- In TPG frames, ACTIVE outputs D_OUT={line[7:0], pixel[7:0]} and no error pulses are raised.
- Without the macro: no tpg_en port; the stream is the only data source.

Test Plan:
- Nominal frame: WIDTH=4, HEIGHT=2, porches 3/2/3/2, FRAME_GAP=4; continuous tvalid; tuser on pixel 0; tlast on pixel 3 -> FV high 3+2*(3+4+2)+2=23 cycles, LV high 4 cycles twice, D_OUT matches input order, no error pulses, one frame_done.
- Resync: send 5 beats with tuser=0, then an SOF -> all 5 dropped with tready=1, FV rises the cycle after the SOF is seen, first D_OUT equals the SOF data.
- Underrun: drop tvalid for pixel 2 of line 1 -> LV stays high, D_OUT=0 that cycle, one err_underrun, frame length unchanged.
- tlast errors: tlast on pixel 1, and separately missing tlast on pixel 3 -> one err_tlast each; stray tuser on line 1 pixel 0 -> one err_sof.
- Reset mid-ACTIVE: assert reset asynchronously -> FV/LV/tready go 0 without waiting for an edge; after release, the next frame waits for an SOF.
- With CAM_TX_TPG_EN and tpg_en=1 -> tready=0 throughout; line 1 pixel 3 outputs D_OUT=16'h0103.
